// File: rtl/femto_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package femto_pkg;

  // Which requester owns the access whose read data returns next cycle.
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DREAD = 2'd2
  } owner_e;

  // Default number of back-to-back data grants tolerated while fetch waits.
  localparam int unsigned STARVE_LIMIT_DEF = 4;

  // Width of the starvation streak counter (limit must fit, 1..15).
  localparam int unsigned STREAK_W = 4;

  // Byte-offset bits dropped when turning a byte address into a word address.
  localparam int unsigned BYTE_OFF_W = 2;

endpackage

// File: rtl/arb_pick.sv
// Combinational priority decision: data first, fetch once the streak hits the limit.
module arb_pick
  import femto_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                i_req,
  input  logic                d_req,
  input  logic [STREAK_W-1:0] streak,
  output logic                i_gnt,
  output logic                d_gnt
);

  logic starved;

  // Data wins unless fetch has been passed over STARVE_LIMIT times in a row.
  always_comb begin
    starved = (streak == STREAK_W'(STARVE_LIMIT));
    d_gnt   = d_req & ~(i_req & starved);
    i_gnt   = i_req & ~d_gnt;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and load/store.
module mem_arbiter
  import femto_pkg::*;
#(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_wmask,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned ADDR_HI = ADDR_W + BYTE_OFF_W - 1;

  owner_e              owner_q;
  owner_e              owner_d;
  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] streak_d;
  logic [31:0]         i_rdata_q;
  logic [31:0]         d_rdata_q;
  logic                fetch_req;
  logic                data_req;
  logic                unused_addr_bits;

  // Requests are masked while in reset so no grant can escape.
  assign fetch_req = i_req & resetn;
  assign data_req  = d_req & resetn;

  // Address bits outside the RAM word range are intentionally ignored (wrap).
  assign unused_addr_bits = ^{i_addr[31:ADDR_HI+1], i_addr[BYTE_OFF_W-1:0],
                              d_addr[31:ADDR_HI+1], d_addr[BYTE_OFF_W-1:0]};

  arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .i_req (fetch_req),
    .d_req (data_req),
    .streak(streak_q),
    .i_gnt (i_gnt),
    .d_gnt (d_gnt)
  );

  // State register: in-flight owner and starvation streak.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner_q  <= OWN_NONE;
      streak_q <= '0;
    end else begin
      owner_q  <= owner_d;
      streak_q <= streak_d;
    end
  end

  // Next state: record who owns the return; count data grants fetch waited through.
  always_comb begin
    owner_d  = OWN_NONE;
    streak_d = '0;
    if (i_gnt) begin
      owner_d = OWN_FETCH;
    end else if (d_gnt && !d_we) begin
      owner_d = OWN_DREAD;
    end
    if (i_req && d_gnt) begin
      streak_d = (streak_q == STREAK_W'(STARVE_LIMIT)) ? streak_q
                                                       : streak_q + STREAK_W'(1);
    end
  end

  // Hold the last returned word per requester between rvalid pulses.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (owner_q == OWN_FETCH) begin
        i_rdata_q <= mem_rdata;
      end
      if (owner_q == OWN_DREAD) begin
        d_rdata_q <= mem_rdata;
      end
    end
  end

  // Outputs: route returning RAM data and drive the RAM port for the granted access.
  always_comb begin
    i_rvalid  = (owner_q == OWN_FETCH);
    d_rvalid  = (owner_q == OWN_DREAD);
    i_rdata   = i_rdata_q;
    d_rdata   = d_rdata_q;
    mem_en    = i_gnt | d_gnt;
    mem_we    = '0;
    mem_addr  = i_addr[ADDR_HI:BYTE_OFF_W];
    mem_wdata = d_wdata;
    if (owner_q == OWN_FETCH) begin
      i_rdata = mem_rdata;
    end
    if (owner_q == OWN_DREAD) begin
      d_rdata = mem_rdata;
    end
    if (d_gnt) begin
      mem_addr = d_addr[ADDR_HI:BYTE_OFF_W];
      if (d_we) begin
        mem_we = d_wmask;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic vs a reference model.
module tb_mem_arbiter;

  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int          LIM   = 4;

  logic          clk;
  logic          resetn;
  logic          i_req;
  logic [31:0]   i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [31:0]   i_rdata;
  logic          d_req;
  logic          d_we;
  logic [3:0]    d_wmask;
  logic [31:0]   d_addr;
  logic [31:0]   d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [31:0]   d_rdata;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(
    .ADDR_W      (AW),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_gnt    (i_gnt),
    .i_rvalid (i_rvalid),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_wmask  (d_wmask),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int k);
    if (k == 0) return 32'h00500093;
    if (k == 4) return 32'h11223344;
    return (32'(k) * 32'h9E3779B1) ^ 32'hC001D00D;
  endfunction

  // Synchronous single-port RAM attached to the arbiter's memory port.
  logic [31:0] ram [0:DEPTH-1];
  bit          ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int k = 0; k < int'(DEPTH); k++) ram[k] <= init_word(k);
      ram_ready <= 1'b1;
    end else if (mem_en) begin
      mem_rdata <= ram[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // Reference model: memory image, pending returns, fetch starvation count.
  logic [31:0] ref_mem [0:DEPTH-1];
  int          m_waited;
  bit          pend_i, pend_d;
  logic [31:0] pend_i_data, pend_d_data, last_i, last_d;
  bit          g_i, g_d, no_wait;
  logic        obs_i, obs_d, obs_irv, obs_drv;
  logic [31:0] obs_ird, obs_drd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend_i   = 1'b0;
    pend_d   = 1'b0;
    last_i   = '0;
    last_d   = '0;
    m_waited = 0;
  endtask

  // One clock: drive request fields, check outputs against the model, advance the model.
  task automatic step(input bit ir, input logic [31:0] ia, input bit dr, input bit dwe,
                      input logic [3:0] dm, input logic [31:0] da, input logic [31:0] dd);
    bit eg_i, eg_d;
    int wi, wd;
    if (!no_wait) @(negedge clk);
    no_wait = 1'b0;
    i_req = ir; i_addr = ia; d_req = dr; d_we = dwe; d_wmask = dm; d_addr = da; d_wdata = dd;
    eg_d = dr && !(ir && m_waited >= LIM);
    eg_i = ir && !eg_d;
    wi   = int'(ia[AW+1:2]);
    wd   = int'(da[AW+1:2]);
    #1;
    chk("i_gnt", 32'(i_gnt), 32'(eg_i));
    chk("d_gnt", 32'(d_gnt), 32'(eg_d));
    chk("mem_en", 32'(mem_en), 32'(eg_i | eg_d));
    if (eg_d) begin
      chk("mem_addr_d", 32'(mem_addr), 32'(wd));
      chk("mem_we_d", 32'(mem_we), dwe ? 32'(dm) : 32'd0);
      chk("mem_wdata", mem_wdata, dd);
    end else if (eg_i) begin
      chk("mem_addr_i", 32'(mem_addr), 32'(wi));
      chk("mem_we_i", 32'(mem_we), 32'd0);
    end
    chk("i_rvalid", 32'(i_rvalid), 32'(pend_i));
    chk("i_rdata", i_rdata, pend_i ? pend_i_data : last_i);
    chk("d_rvalid", 32'(d_rvalid), 32'(pend_d));
    chk("d_rdata", d_rdata, pend_d ? pend_d_data : last_d);
    obs_i = i_gnt; obs_d = d_gnt; obs_irv = i_rvalid; obs_drv = d_rvalid;
    obs_ird = i_rdata; obs_drd = d_rdata;
    @(posedge clk);
    if (pend_i) last_i = pend_i_data;
    if (pend_d) last_d = pend_d_data;
    pend_i = eg_i;
    if (eg_i) pend_i_data = ref_mem[wi];
    pend_d = eg_d && !dwe;
    if (pend_d) pend_d_data = ref_mem[wd];
    if (eg_d && dwe)
      for (int b = 0; b < 4; b++)
        if (dm[b]) ref_mem[wd][8*b +: 8] = dd[8*b +: 8];
    if (ir && eg_d) m_waited = (m_waited < LIM) ? m_waited + 1 : LIM;
    else            m_waited = 0;
    g_i = eg_i;
    g_d = eg_d;
  endtask

  initial begin
    logic [9:0]  pat10;
    logic [4:0]  pat5;
    logic [31:0] ia_hold;
    bit          ir, dr, dwe;
    logic [31:0] ia, da, dd;
    logic [3:0]  dm;

    for (int k = 0; k < int'(DEPTH); k++) ref_mem[k] = init_word(k);
    model_reset();
    no_wait = 1'b0;

    // Reset: grants forced low even with both requests up; returns cleared.
    resetn = 1'b0;
    i_req = 1'b1; i_addr = 32'h0; d_req = 1'b1; d_we = 1'b0; d_wmask = 4'h0;
    d_addr = 32'h0; d_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_i_gnt", 32'(i_gnt), 32'd0);
    chk("rst_d_gnt", 32'(d_gnt), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_i_rvalid", 32'(i_rvalid), 32'd0);
    chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    @(negedge clk);
    i_req = 1'b0; d_req = 1'b0;
    resetn = 1'b1;

    // Fetch only, sequential addresses.
    step(1, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    step(1, 32'h4, 0, 0, 4'h0, 32'h0, 32'h0);
    chk("fetch_first_valid", 32'(obs_irv), 32'd1);
    chk("fetch_first_word", obs_ird, 32'h00500093);
    step(1, 32'h8, 0, 0, 4'h0, 32'h0, 32'h0);
    step(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

    // Partial write then readback.
    step(0, 32'h0, 1, 1, 4'b0011, 32'h10, 32'hAABBCCDD);
    step(0, 32'h0, 1, 0, 4'h0, 32'h10, 32'h0);
    chk("no_rvalid_after_write", 32'(obs_drv), 32'd0);
    step(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    chk("merge_valid", 32'(obs_drv), 32'd1);
    chk("merge_data", obs_drd, 32'h1122CCDD);

    // Contention: both held; fetch advances only when granted.
    pat10 = '0;
    ia_hold = 32'h100;
    for (int k = 0; k < 10; k++) begin
      step(1, ia_hold, 1, 0, 4'h0, 32'h200 + 32'(k * 4), 32'h0);
      pat10[k] = obs_i;
      if (g_i) ia_hold = ia_hold + 32'h4;
    end
    chk("starve_order", 32'(pat10), 32'(10'b1000010000));
    step(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

    // Address wrap: byte address 0x1000 aliases word 0; low bits ignored.
    step(0, 32'h0, 1, 1, 4'hF, 32'h1000, 32'hDEADBEEF);
    step(0, 32'h0, 1, 0, 4'h0, 32'h0000, 32'h0);
    step(0, 32'h0, 1, 0, 4'h0, 32'h0003, 32'h0);
    chk("wrap_read0", obs_drd, 32'hDEADBEEF);
    step(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    chk("wrap_read3", obs_drd, 32'hDEADBEEF);

    // Mixed return: fetch then data read on consecutive cycles.
    step(1, 32'h20, 0, 0, 4'h0, 32'h0, 32'h0);
    step(0, 32'h0, 1, 0, 4'h0, 32'h24, 32'h0);
    chk("mixed_irv_n1", 32'(obs_irv), 32'd1);
    chk("mixed_drv_n1", 32'(obs_drv), 32'd0);
    step(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    chk("mixed_irv_n2", 32'(obs_irv), 32'd0);
    chk("mixed_drv_n2", 32'(obs_drv), 32'd1);
    chk("mixed_ddata", obs_drd, ref_mem[9]);

    // Reset in the cycle after a data-read grant drops the pending return.
    step(0, 32'h0, 1, 0, 4'h0, 32'h40, 32'h0);
    #1;
    resetn = 1'b0;
    i_req  = 1'b1;
    i_addr = 32'h300;
    #1;
    model_reset();
    chk("midrst_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("midrst_d_gnt", 32'(d_gnt), 32'd0);
    chk("midrst_d_rdata", d_rdata, 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_d_rvalid2", 32'(d_rvalid), 32'd0);
    @(negedge clk);
    resetn  = 1'b1;
    no_wait = 1'b1;
    pat5 = '0;
    ia_hold = 32'h300;
    for (int k = 0; k < 5; k++) begin
      step(1, ia_hold, 1, 0, 4'h0, 32'h40 + 32'(k * 4), 32'h0);
      pat5[k] = obs_i;
      if (g_i) ia_hold = ia_hold + 32'h4;
    end
    chk("post_rst_order", 32'(pat5), 32'(5'b10000));

    // Random traffic; requesters hold their fields until granted.
    ir = 1'b0; dr = 1'b0; ia = '0; da = '0; dd = '0; dwe = 1'b0; dm = '0;
    for (int k = 0; k < 400; k++) begin
      if (!ir || g_i) begin
        ir = ($urandom_range(0, 9) < 7);
        ia = $urandom();
      end
      if (!dr || g_d) begin
        dr  = ($urandom_range(0, 9) < 6);
        dwe = ($urandom_range(0, 2) == 0);
        dm  = 4'($urandom());
        da  = $urandom();
        dd  = $urandom();
      end
      g_i = 1'b0; g_d = 1'b0;
      step(ir, ia, dr, dwe, dm, da, dd);
    end
    step(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    step(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
